pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/load_use_detect.sv | 20 ++
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM states, NOP encoding and the
// per-mode pipeline-control bundles driven by pipe_hazard_ctrl.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StMemWait
    } hz_state_e;

    localparam logic [31:0] NopInstr = 32'h0000_0013;
    localparam logic [4:0]  RegZero  = 5'd0;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CtrlRun       = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b0,
                                             idex_we: 1'b1, idex_bubble: 1'b0};
    localparam pipe_ctrl_t CtrlReset     = '{pc_we: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1,
                                             idex_we: 1'b1, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CtrlFreeze    = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                             idex_we: 1'b0, idex_bubble: 1'b0};
    localparam pipe_ctrl_t CtrlFlush     = '{pc_we: 1'b1, ifid_we: 1'b1, ifid_flush: 1'b1,
                                             idex_we: 1'b1, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CtrlLoadUse   = '{pc_we: 1'b0, ifid_we: 1'b0, ifid_flush: 1'b0,
                                             idex_we: 1'b1, idex_bubble: 1'b1};
    localparam pipe_ctrl_t CtrlFetchWait = '{pc_we: 1'b0, ifid_we: 1'b1, ifid_flush: 1'b1,
                                             idex_we: 1'b1, idex_bubble: 1'b0};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare: the load in EX writes a register the instruction in ID reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rd,
    input  logic [4:0] ifid_rs1,
    input  logic [4:0] ifid_rs2,
    input  logic       rs1_used,
    input  logic       rs2_used,
    output logic       load_use
);

    always_comb begin
        load_use = idex_mem_read && (idex_rd != RegZero) &&
                   ((rs1_used && (idex_rd == ifid_rs1)) ||
                    (rs2_used && (idex_rd == ifid_rs2)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: freezes on data-memory wait, flushes after taken branches,
// stalls on load-use and fetch misses, and counts PC-stall cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_ready,
    input  logic        dmem_busy,
    input  logic        branch_taken,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    input  logic [4:0]  ifid_rs1,
    input  logic [4:0]  ifid_rs2,
    input  logic        rs1_used,
    input  logic        rs2_used,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_we,
    output logic        idex_bubble,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

    hz_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        load_use;
    logic        flushing;
    pipe_ctrl_t  ctrl;

    load_use_detect u_load_use_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .ifid_rs1      (ifid_rs1),
        .ifid_rs2      (ifid_rs2),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .load_use      (load_use)
    );

    // Leaving MEM_WAIT resumes the interrupted flush in the same cycle if one was pending.
    always_comb begin
        flushing = (state_q == StFlush) || ((state_q == StMemWait) && (cnt_q != 2'd0));
    end

    always_comb begin
        ctrl    = CtrlRun;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rst) begin
            ctrl    = CtrlReset;
            state_d = StRun;
            cnt_d   = 2'd0;
        end else if (dmem_busy) begin
            ctrl    = CtrlFreeze;
            state_d = StMemWait;
        end else if (branch_taken) begin
            ctrl    = CtrlFlush;
            cnt_d   = FlushInit;
            state_d = (FlushInit != 2'd0) ? StFlush : StRun;
        end else if (flushing) begin
            ctrl    = CtrlFlush;
            cnt_d   = (cnt_q != 2'd0) ? (cnt_q - 2'd1) : 2'd0;
            state_d = (cnt_d != 2'd0) ? StFlush : StRun;
        end else begin
            state_d = StRun;
            if (load_use) begin
                ctrl = CtrlLoadUse;
            end else if (!imem_ready) begin
                ctrl = CtrlFetchWait;
            end
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (rst) begin
            stall_d = 16'd0;
        end else if (!ctrl.pc_we && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        stall_q <= stall_d;
    end

    always_comb begin
        pc_we       = ctrl.pc_we;
        ifid_we     = ctrl.ifid_we;
        ifid_flush  = ctrl.ifid_flush;
        idex_we     = ctrl.idex_we;
        idex_bubble = ctrl.idex_bubble;
        stall_cnt   = stall_q;
    end

endmodule
